spi_regfile: RTL and testbench

SPI_REGFILE -- requirements
Module: spi_regfile

---
 rtl/spi_regfile.sv | 174 +++++++++++++++++
 tb/tb_spi_regfile.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 peripheral feeding a small write-only register file, all inputs oversampled on clk.
// Define SPI_REGFILE_READBACK_EN to shift the addressed register out on cipo during read frames.
module spi_regfile #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ncs,
    input  logic                       copi,
    input  logic                       sclk,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic [NUM_REGS-1:0]        wr_stb
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    // One extra count of headroom so the saturation value FRAME_W+1 always fits.
    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_ADDR_END  = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FRAME_END = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(FRAME_W + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAME_W-1:0]  sr_q, sr_d;
    logic [2:0]          ncs_sync, sclk_sync;
    logic [1:0]          copi_sync;
    logic                ncs_low, ncs_rise, ncs_fall, sclk_rise, commit;
    logic                f_rw;
    logic [ADDR_W-1:0]   f_addr;
    logic [DATA_W-1:0]   f_data;
    logic [DATA_W-1:0]   reg_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_sync  <= 3'b111;
            sclk_sync <= '0;
            copi_sync <= '0;
        end else begin
            ncs_sync  <= {ncs_sync[1:0], ncs};
            sclk_sync <= {sclk_sync[1:0], sclk};
            copi_sync <= {copi_sync[0], copi};
        end
    end

    assign ncs_low   = ~ncs_sync[1];
    assign ncs_rise  = ncs_sync[1] & ~ncs_sync[2];
    assign ncs_fall  = ~ncs_sync[1] & ncs_sync[2];
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];

    assign f_rw   = sr_q[FRAME_W-1];
    assign f_addr = sr_q[DATA_W +: ADDR_W];
    assign f_data = sr_q[DATA_W-1:0];

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        if (ncs_rise) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (ncs_fall) begin
            state_d = ADDR;
            cnt_d   = '0;
        end else if (sclk_rise && ncs_low) begin
            case (state_q)
                ADDR, DATA: begin
                    sr_d  = {sr_q[FRAME_W-2:0], copi_sync[1]};
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == ADDR && cnt_d == CNT_ADDR_END)
                        state_d = DATA;
                    if (state_q == DATA && cnt_d == CNT_FRAME_END)
                        state_d = DONE;
                end
                DONE, ERR: begin
                    state_d = ERR;
                    if (cnt_q != CNT_SAT)
                        cnt_d = cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    // Only a complete write frame closed by ncs commits; out-of-range addresses match no register.
    assign commit = ncs_rise && (state_q == DONE) && f_rw;

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (f_addr == ADDR_W'(k))
                wr_sel[k] = commit;
    end

    // NOTE: the register array is small and must read as zero after reset, so it is reset explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++)
                reg_q[k] <= '0;
            wr_stb <= '0;
        end else begin
            wr_stb <= wr_sel;
            for (int k = 0; k < NUM_REGS; k++)
                if (wr_sel[k])
                    reg_q[k] <= f_data;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign regs[k*DATA_W +: DATA_W] = reg_q[k];
    end

`ifdef SPI_REGFILE_READBACK_EN
    logic              sclk_fall, rb_load, shift_out, cipo_q, oe_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_val, tx_q;

    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign rd_addr   = sr_d[ADDR_W-1:0];
    assign rb_load   = (state_q == ADDR) && (state_d == DATA) && !sr_d[ADDR_W];
    // The falling edge right after the last address bit must not shift; wait for a data sample first.
    assign shift_out = sclk_fall && ncs_low && (state_q == DATA) && (cnt_q > CNT_ADDR_END);

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (rd_addr == ADDR_W'(k))
                rd_val = reg_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q   <= '0;
            cipo_q <= 1'b0;
            oe_q   <= 1'b0;
        end else if (ncs_rise || ncs_fall) begin
            cipo_q <= 1'b0;
            oe_q   <= 1'b0;
        end else if (rb_load) begin
            {cipo_q, tx_q} <= {rd_val, 1'b0};
            oe_q           <= 1'b1;
        end else if (shift_out) begin
            cipo_q <= tx_q[DATA_W-1];
            tx_q   <= tx_q << 1;
        end
    end

    assign cipo    = cipo_q;
    assign cipo_oe = oe_q;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: directed SPI frames against two spi_regfile instances (default and 16x16/4-bit address),
// checked every cycle against a frame-level register model plus hand-computed literal expectations.
module tb_spi_regfile;
    localparam int N0 = 5;
    localparam int D0 = 8;
    localparam int A0 = 7;
    localparam int N1 = 16;
    localparam int D1 = 16;
    localparam int A1 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic copi = 1'b0;
    logic ncs0 = 1'b1;
    logic ncs1 = 1'b1;
    logic cipo0, oe0, cipo1, oe1;
    logic [N0*D0-1:0] regs0;
    logic [N1*D1-1:0] regs1;
    logic [N0-1:0] stb0;
    logic [N1-1:0] stb1;

    always #5 clk = ~clk;

    spi_regfile dut0 (
        .clk(clk), .rst(rst), .ncs(ncs0), .copi(copi), .sclk(sclk),
        .cipo(cipo0), .cipo_oe(oe0), .regs(regs0), .wr_stb(stb0)
    );

    spi_regfile #(.NUM_REGS(N1), .DATA_W(D1), .ADDR_W(A1)) dut1 (
        .clk(clk), .rst(rst), .ncs(ncs1), .copi(copi), .sclk(sclk),
        .cipo(cipo1), .cipo_oe(oe1), .regs(regs1), .wr_stb(stb1)
    );

    int errors = 0;
    int checks = 0;

    // Frame-level model: register values and the expected strobe for the current cycle.
    logic [31:0] m0 [N0];
    logic [31:0] m1 [N1];
    logic [N0-1:0] e_stb0 = '0;
    logic [N1-1:0] e_stb1 = '0;
    logic [N0*D0-1:0] er0;
    logic [N1*D1-1:0] er1;
    logic [N0-1:0] stb_or0 = '0;
    logic [N1-1:0] stb_or1 = '0;
    int stb_cyc0 = 0;
    int stb_cyc1 = 0;
    bit bus_idle = 1'b1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N0; k++) m0[k] = '0;
        for (int k = 0; k < N1; k++) m1[k] = '0;
        e_stb0 = '0;
        e_stb1 = '0;
    endtask

    task automatic clr_acc();
        stb_or0 = '0;
        stb_or1 = '0;
        stb_cyc0 = 0;
        stb_cyc1 = 0;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N0; k++) er0[k*D0 +: D0] = m0[k][D0-1:0];
        for (int k = 0; k < N1; k++) er1[k*D1 +: D1] = m1[k][D1-1:0];
        check("regs0_model", 256'(regs0), 256'(er0));
        check("regs1_model", 256'(regs1), 256'(er1));
        check("stb0_model", 256'(stb0), 256'(e_stb0));
        check("stb1_model", 256'(stb1), 256'(e_stb1));
`ifndef SPI_REGFILE_READBACK_EN
        check("cipo_tied", 256'({cipo0, oe0, cipo1, oe1}), 256'(0));
`else
        if (bus_idle)
            check("oe_idle", 256'({oe0, oe1}), 256'(0));
`endif
        stb_or0 |= stb0;
        stb_or1 |= stb1;
        if (stb0 != '0) stb_cyc0++;
        if (stb1 != '0) stb_cyc1++;
    end

    task automatic set_ncs(input int which, input logic v);
        if (which == 0) ncs0 = v;
        else ncs1 = v;
    endtask

    task automatic start_frame(input int which);
        @(negedge clk);
        bus_idle = 1'b0;
        set_ncs(which, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    // Shifts n bits MSB first; on read checks, cipo must already hold each data bit before sclk rises.
    task automatic shift_bits(input int which, input logic [63:0] bits, input int n,
                              input bit chk, input logic [31:0] rd_exp);
        int aw;
        int dw;
        aw = (which == 0) ? A0 : A1;
        dw = (which == 0) ? D0 : D1;
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            sclk = 1'b0;
            copi = bits[n-1-p];
            repeat (4) @(negedge clk);
`ifdef SPI_REGFILE_READBACK_EN
            if (chk && p >= 1 + aw && p < 1 + aw + dw) begin
                check("cipo_bit", 256'((which == 0) ? cipo0 : cipo1), 256'(rd_exp[dw-1-(p-1-aw)]));
                check("cipo_oe_data", 256'((which == 0) ? oe0 : oe1), 256'(1));
            end
`endif
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        @(negedge clk);
        sclk = 1'b0;
    endtask

    // Raises ncs and applies the frame rule: only an exact-length write to an existing register commits,
    // three clk edges after ncs rises (two synchroniser stages, then the commit edge).
    task automatic end_frame(input int which, input logic [63:0] bits, input int n);
        int aw;
        int dw;
        int nr;
        logic [31:0] addr;
        logic [31:0] data;
        aw = (which == 0) ? A0 : A1;
        dw = (which == 0) ? D0 : D1;
        nr = (which == 0) ? N0 : N1;
        repeat (4) @(negedge clk);
        set_ncs(which, 1'b1);
        repeat (3) @(posedge clk);
        if (n == 1 + aw + dw && bits[n-1]) begin
            addr = 32'((bits >> dw) & ((64'd1 << aw) - 64'd1));
            data = 32'(bits & ((64'd1 << dw) - 64'd1));
            if (addr < 32'(nr)) begin
                if (which == 0) begin
                    m0[addr] = data;
                    for (int k = 0; k < N0; k++) e_stb0[k] = (32'(k) == addr);
                end else begin
                    m1[addr] = data;
                    for (int k = 0; k < N1; k++) e_stb1[k] = (32'(k) == addr);
                end
            end
        end
        @(posedge clk);
        e_stb0 = '0;
        e_stb1 = '0;
        repeat (4) @(negedge clk);
        bus_idle = 1'b1;
    endtask

    task automatic frame(input int which, input logic [63:0] bits, input int n);
        start_frame(which);
        shift_bits(which, bits, n, 1'b0, 32'd0);
        end_frame(which, bits, n);
    endtask

    task automatic write(input int which, input int addr, input logic [31:0] data);
        int aw;
        int dw;
        logic [63:0] bits;
        aw = (which == 0) ? A0 : A1;
        dw = (which == 0) ? D0 : D1;
        bits = (64'd1 << (aw + dw)) | (64'(addr) << dw) | 64'(data);
        frame(which, bits, 1 + aw + dw);
    endtask

    task automatic read(input int which, input int addr, input logic [31:0] exp);
        int dw;
        int aw;
        logic [63:0] bits;
        aw = (which == 0) ? A0 : A1;
        dw = (which == 0) ? D0 : D1;
        bits = 64'(addr) << dw;
        start_frame(which);
        shift_bits(which, bits, 1 + aw + dw, 1'b1, exp);
        end_frame(which, bits, 1 + aw + dw);
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check("reset_regs0", 256'(regs0), 256'(0));
        check("reset_regs1", 256'(regs1), 256'(0));
        check("reset_stb", 256'({stb0, stb1}), 256'(0));
        check("reset_cipo", 256'({cipo0, oe0, cipo1, oe1}), 256'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write addr 2 with 0xAA.
        clr_acc();
        frame(0, 64'({1'b1, 7'b0000010, 8'b10101010}), 16);
        check("w2_regs", 256'(regs0), 256'(40'h00_00_AA_00_00));
        check("w2_stb", 256'(stb_or0), 256'(5'b00100));
        check("w2_stb_len", 256'(stb_cyc0), 256'(1));

        // Addr 4 = 0xFF, then a 15-bit frame aimed at addr 4 must not commit.
        write(0, 4, 32'hFF);
        clr_acc();
        frame(0, 64'({1'b1, 7'd4, 7'd0}), 15);
        check("short_regs4", 256'(regs0[39:32]), 256'(8'hFF));
        check("short_stb", 256'(stb_or0), 256'(0));

        // 17-bit frame to addr 0, then an out-of-range address.
        clr_acc();
        frame(0, 64'({1'b1, 7'd0, 8'h55, 1'b1}), 17);
        check("long_regs0", 256'(regs0[7:0]), 256'(8'h00));
        write(0, 9, 32'h12);
        check("oor_regs", 256'(regs0), 256'(40'hFF_00_AA_00_00));
        check("long_oor_stb", 256'(stb_or0), 256'(0));

        // Read frames never write; readback shifts the register MSB first.
        clr_acc();
        read(0, 2, m0[2]);
        write(0, 1, 32'h3C);
        read(0, 1, 32'h3C);
        read(0, 7, 32'h00);
        check("read_stb", 256'(stb_or0), 256'(5'b00010));
        check("read_regs", 256'(regs0), 256'(40'hFF_00_AA_3C_00));

        // sclk toggling with ncs high is ignored; the next frame still writes normally.
        shift_bits(0, 64'b10101, 5, 1'b0, 32'd0);
        write(0, 3, 32'h5A);
        check("ign_regs3", 256'(regs0[31:24]), 256'(8'h5A));

        // ncs glitch mid-frame restarts the frame from the address field.
        start_frame(0);
        shift_bits(0, 64'b11111, 5, 1'b0, 32'd0);
        @(negedge clk);
        ncs0 = 1'b1;
        @(negedge clk);
        ncs0 = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(0, 64'({1'b1, 7'd0, 8'hC3}), 16, 1'b0, 32'd0);
        end_frame(0, 64'({1'b1, 7'd0, 8'hC3}), 16);
        check("glitch_regs0", 256'(regs0[7:0]), 256'(8'hC3));

        // Reset after 10 bits of a write to addr 0 discards the frame and clears everything.
        start_frame(0);
        shift_bits(0, 64'b1000000001, 10, 1'b0, 32'd0);
        @(posedge clk);
        rst = 1'b1;
        ncs0 = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus_idle = 1'b1;
        check("rst_regs", 256'(regs0), 256'(0));
        repeat (4) @(negedge clk);
        write(0, 0, 32'h81);
        check("post_rst_w0", 256'(regs0[7:0]), 256'(8'h81));

        // Wide instance: 16 registers of 16 bits, 4-bit address.
        clr_acc();
        write(1, 15, 32'hBEEF);
        check("w15_regs", 256'(regs1[255:240]), 256'(16'hBEEF));
        check("w15_stb", 256'(stb_or1), 256'(16'h8000));
        write(1, 3, 32'h1234);
        frame(1, 64'({1'b1, 4'd3, 16'hFFFF, 1'b0}), 22);
        check("w3_regs", 256'(regs1[63:48]), 256'(16'h1234));
        read(1, 15, 32'hBEEF);
        check("wide_stb_total", 256'(stb_or1), 256'(16'h8008));
        check("narrow_untouched", 256'(regs0), 256'(40'h00_00_00_00_81));

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
